// File: rtl/display_scan_pkg.sv
// Shared constants for the multiplexed 4-digit seven-segment scanner.
// Pure definitions; no latency, no flow control.
// Segment codes are active-low with segments a..g on bits 0..6.
package display_scan_pkg;

    localparam int DEF_PRESCALE = 50000;
    localparam int DEF_BLANK    = 16;
    localparam int NUM_DIGITS   = 4;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Entry n is the glyph for hex value n (index 15 is listed first).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/display_scan_decod7seg.sv
// Hex nibble to active-low seven-segment glyph.
// Combinational, zero latency; no flow control.
module decod7seg
    import display_scan_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed scan of four hex digits with per-slot ghost blanking.
// Outputs registered, aligned to the cnt/idx of the same cycle; inputs shadowed per frame.
// No backpressure: free-running scan, inputs sampled once per frame.
module display_scan
    import display_scan_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int BLANK    = DEF_BLANK
)(
    input  logic        CK,
    input  logic        reset,
    input  logic [15:0] dado,
    input  logic [3:0]  pontos,
    input  logic        habilita,
    input  logic        zeros_esq,
    output logic [3:0]  anodo,
    output logic [6:0]  segmentos,
    output logic        ponto,
    output logic        quadro
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0]           cnt, cnt_nxt;
    logic [1:0]              idx, idx_nxt;
    logic                    slot_end, frame_end;
    logic [15:0]             dado_sh, dado_sh_nxt;
    logic [3:0]              pontos_sh, pontos_sh_nxt;
    logic                    zeros_sh, zeros_sh_nxt;
    logic [3:0]              nib;
    logic [6:0]              seg_dec;
    logic [NUM_DIGITS-1:0]   blank_vec;
    phase_e                  phase_nxt;
    logic                    show;
    logic [3:0]              anodo_nxt;
    logic [6:0]              seg_nxt;
    logic                    ponto_nxt;

    always_comb begin
        slot_end  = (cnt == CW'(PRESCALE - 1));
        frame_end = slot_end && (idx == 2'd3);
        cnt_nxt   = slot_end ? '0 : cnt + 1'b1;
        idx_nxt   = slot_end ? idx + 2'd1 : idx;

        dado_sh_nxt   = frame_end ? dado      : dado_sh;
        pontos_sh_nxt = frame_end ? pontos    : pontos_sh;
        zeros_sh_nxt  = frame_end ? zeros_esq : zeros_sh;
    end

    // Outputs are built from next-state values so the registered result
    // lines up with the slot the counters enter on the same edge.
    assign nib = dado_sh_nxt[{idx_nxt, 2'b00} +: 4];

    decod7seg u_decod (
        .hex (nib),
        .seg (seg_dec)
    );

    always_comb begin
        blank_vec[0] = 1'b0;
        blank_vec[1] = zeros_sh_nxt && (dado_sh_nxt[15:4]  == 12'h000);
        blank_vec[2] = zeros_sh_nxt && (dado_sh_nxt[15:8]  == 8'h00);
        blank_vec[3] = zeros_sh_nxt && (dado_sh_nxt[15:12] == 4'h0);

        phase_nxt = (cnt_nxt < CW'(BLANK)) ? PH_BLANK : PH_SHOW;
        show      = (phase_nxt == PH_SHOW) && habilita && !blank_vec[idx_nxt];

        anodo_nxt = 4'hF;
        seg_nxt   = SEG_OFF;
        ponto_nxt = 1'b1;
        if (show) begin
            anodo_nxt = ~(4'b0001 << idx_nxt);
            seg_nxt   = seg_dec;
            ponto_nxt = ~pontos_sh_nxt[idx_nxt];
        end
    end

    always_ff @(posedge CK) begin
        if (reset) begin
            cnt       <= '0;
            idx       <= '0;
            dado_sh   <= '0;
            pontos_sh <= '0;
            zeros_sh  <= 1'b0;
            anodo     <= 4'hF;
            segmentos <= SEG_OFF;
            ponto     <= 1'b1;
            quadro    <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            dado_sh   <= dado_sh_nxt;
            pontos_sh <= pontos_sh_nxt;
            zeros_sh  <= zeros_sh_nxt;
            anodo     <= anodo_nxt;
            segmentos <= seg_nxt;
            ponto     <= ponto_nxt;
            quadro    <= frame_end;
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan: a cycle-count reference model queues the
// expected outputs per clock edge; a monitor pops and compares on the falling edge.
module tb_display_scan;

    localparam int PRESCALE = 8;
    localparam int BLANK    = 2;
    localparam int FRAME    = PRESCALE * 4;

    logic        CK = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] dado = '0;
    logic [3:0]  pontos = '0;
    logic        habilita = 1'b0;
    logic        zeros_esq = 1'b0;
    logic [3:0]  anodo;
    logic [6:0]  segmentos;
    logic        ponto;
    logic        quadro;

    display_scan #(.PRESCALE(PRESCALE), .BLANK(BLANK)) dut (
        .CK        (CK),
        .reset     (reset),
        .dado      (dado),
        .pontos    (pontos),
        .habilita  (habilita),
        .zeros_esq (zeros_esq),
        .anodo     (anodo),
        .segmentos (segmentos),
        .ponto     (ponto),
        .quadro    (quadro)
    );

    always #5 CK = ~CK;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       pt;
        logic       qd;
    } obs_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    logic [6:0] hex_seg [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Reference state: cycles elapsed since the last reset edge, plus the frame snapshot.
    int          t = 0;
    logic [15:0] sh_dado = '0;
    logic [3:0]  sh_pontos = '0;
    logic        sh_zeros = 1'b0;

    task automatic model_edge();
        obs_t e;
        int d;
        int ph;
        bit blanked;
        logic [3:0] nib;
        if (reset) begin
            t = 0;
            sh_dado = '0;
            sh_pontos = '0;
            sh_zeros = 1'b0;
            e = '{an: 4'hF, seg: 7'h7F, pt: 1'b1, qd: 1'b0};
        end else begin
            t++;
            if (t % FRAME == 0) begin
                sh_dado = dado;
                sh_pontos = pontos;
                sh_zeros = zeros_esq;
            end
            d  = (t / PRESCALE) % 4;
            ph = t % PRESCALE;
            blanked = (d != 0) && sh_zeros && ((sh_dado >> (4 * d)) == 16'h0);
            nib = sh_dado[4*d +: 4];
            e = '{an: 4'hF, seg: 7'h7F, pt: 1'b1, qd: (t % FRAME == 0)};
            if (ph >= BLANK && habilita && !blanked) begin
                e.an  = 4'hF & ~(4'h1 << d);
                e.seg = hex_seg[nib];
                e.pt  = ~sh_pontos[d];
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge CK);
        model_edge();
        @(negedge CK);
    endtask

    initial begin : monitor
        obs_t e;
        obs_t got;
        forever begin
            @(negedge CK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = '{an: anodo, seg: segmentos, pt: ponto, qd: quadro};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0d: got anodo=%b seg=%h ponto=%b quadro=%b, want anodo=%b seg=%h ponto=%b quadro=%b",
                             t, got.an, got.seg, got.pt, got.qd, e.an, e.seg, e.pt, e.qd);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] r;
        @(negedge CK);
        reset = 1'b1;
        repeat (3) tick();

        reset = 1'b0;
        dado = 16'h1234;
        habilita = 1'b1;
        zeros_esq = 1'b0;
        pontos = 4'b0000;
        repeat (40) tick();

        for (int i = 0; i < 40 && ((t / PRESCALE) % 4) != 1; i++) tick();
        dado = 16'hFFFF;
        repeat (70) tick();

        zeros_esq = 1'b1;
        dado = 16'h0007;
        repeat (70) tick();
        dado = 16'h0000;
        repeat (70) tick();

        zeros_esq = 1'b0;
        dado = 16'h5A3C;
        habilita = 1'b0;
        repeat (70) tick();
        habilita = 1'b1;
        pontos = 4'b0100;
        repeat (70) tick();

        for (int i = 0; i < 40 && (t % FRAME) != (2 * PRESCALE + 5); i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (40) tick();

        repeat (2500) begin
            if ($urandom_range(7, 0) == 0) begin
                r = $urandom;
                dado = r[15:0] >> $urandom_range(16, 0);
            end
            if ($urandom_range(15, 0) == 0) pontos = 4'($urandom);
            if ($urandom_range(31, 0) == 0) zeros_esq = ~zeros_esq;
            if ($urandom_range(15, 0) == 0) habilita = ($urandom_range(3, 0) != 0);
            reset = ($urandom_range(299, 0) == 0);
            tick();
        end
        reset = 1'b0;

        repeat (3) @(negedge CK);
        #1;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
